// File: rtl/aes_round_sequencer_pkg.sv
// Shared AES-128 definitions: block type, sequencer states, S-box, round
// constants and the byte-level round transforms used by the sequencer.
`timescale 1ns/1ps
package aes_round_sequencer_pkg;

  localparam int NUM_ROUNDS  = 10;
  localparam int BLOCK_BYTES = 16;

  // Byte i lives in bits [8i+7:8i]; i = 4*col + row.
  typedef logic [BLOCK_BYTES-1:0][7:0] aes_block_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } seq_state_t;

  localparam logic [7:0] SUB_BYTES_TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Indexed by round number 1..10; entry 0 and 11..15 are never used.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  // Multiply by x in GF(2^8) with the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic aes_block_t sub_bytes(input aes_block_t s);
    aes_block_t r;
    for (int i = 0; i < BLOCK_BYTES; i++) r[i] = SUB_BYTES_TABLE[s[i]];
    return r;
  endfunction

  // Row w is rotated left by w columns.
  function automatic aes_block_t shift_rows(input aes_block_t s);
    aes_block_t r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++) r[4*c+w] = s[4*((c+w)%4)+w];
    return r;
  endfunction

  function automatic aes_block_t mix_columns(input aes_block_t s);
    aes_block_t r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[4*c];
      a1 = s[4*c+1];
      a2 = s[4*c+2];
      a3 = s[4*c+3];
      r[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  // Full middle round and final round (final round skips MixColumns).
  function automatic aes_block_t main_cycle(input aes_block_t s, input aes_block_t k);
    return mix_columns(shift_rows(sub_bytes(s))) ^ k;
  endfunction

  function automatic aes_block_t last_cycle(input aes_block_t s, input aes_block_t k);
    return shift_rows(sub_bytes(s)) ^ k;
  endfunction

endpackage

// File: rtl/aes_round_sequencer_key_step.sv
// One AES-128 key-schedule step: current round key + rcon -> next round key.
`timescale 1ns/1ps
module aes_round_sequencer_key_step
  import aes_round_sequencer_pkg::*;
(
  input  logic [127:0] key_i,
  input  logic [7:0]   rcon_i,
  output logic [127:0] key_o
);

  aes_block_t       k_in;
  aes_block_t       k_out;
  logic [3:0][7:0]  temp;

  assign k_in  = key_i;
  assign key_o = k_out;

  // SubWord(RotWord(w3)) ^ rcon, then chain the XOR through w0..w3.
  always_comb begin
    temp  = '0;
    k_out = '0;
    for (int r = 0; r < 4; r++) temp[r] = SUB_BYTES_TABLE[k_in[12+((r+1)%4)]];
    temp[0] = temp[0] ^ rcon_i;
    for (int r = 0; r < 4; r++) begin
      k_out[r]    = k_in[r]    ^ temp[r];
      k_out[4+r]  = k_in[4+r]  ^ k_out[r];
      k_out[8+r]  = k_in[8+r]  ^ k_out[4+r];
      k_out[12+r] = k_in[12+r] ^ k_out[8+r];
    end
  end

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryptor: one round per clock over a single shared round
// datapath, valid/ready on both the block input and the ciphertext output.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits for ready, and out_valid/out_block stay frozen
// until their transfer (or a flush/reset). in_ready is combinational: in DONE
// it follows out_ready so a new block can load on the output-transfer edge.
`timescale 1ns/1ps
module aes_round_sequencer (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy,
  output logic [3:0]   round_idx
);
  import aes_round_sequencer_pkg::*;

  seq_state_t fsm_q, fsm_d;
  aes_block_t blk_q, blk_d;
  aes_block_t key_q, key_d;
  logic [3:0] round_q, round_d;

  logic       accept;
  logic       last_round;
  logic [127:0] key_nxt;
  aes_block_t sr_blk;
  aes_block_t round_out;

  aes_round_sequencer_key_step u_key_step (
    .key_i  (key_q),
    .rcon_i (RCON[round_q]),
    .key_o  (key_nxt)
  );

  // Main and final rounds share SubBytes/ShiftRows; only MixColumns differs.
  assign last_round = (round_q == 4'(NUM_ROUNDS));
  assign sr_blk     = shift_rows(sub_bytes(blk_q));
  assign round_out  = (last_round ? sr_blk : mix_columns(sr_blk)) ^ key_nxt;

  assign in_ready  = !rst && !flush && ((fsm_q == IDLE) || ((fsm_q == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (fsm_q == DONE) && !flush;
  assign out_block = blk_q;
  assign busy      = (fsm_q == ROUND);
  assign round_idx = round_q;

  // State, key, round counter and FSM registers; cleared at once by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= IDLE;
      blk_q   <= '0;
      key_q   <= '0;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      blk_q   <= blk_d;
      key_q   <= key_d;
      round_q <= round_d;
    end
  end

  // Next-state: load on accept, one round per ROUND cycle, hold in DONE.
  always_comb begin
    fsm_d   = fsm_q;
    blk_d   = blk_q;
    key_d   = key_q;
    round_d = round_q;
    if (flush) begin
      fsm_d   = IDLE;
      round_d = '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (accept) begin
            blk_d   = in_block ^ in_key;
            key_d   = in_key;
            round_d = 4'd1;
            fsm_d   = ROUND;
          end
        end
        ROUND: begin
          blk_d = round_out;
          key_d = key_nxt;
          if (!last_round) round_d = round_q + 4'd1;
          else             fsm_d   = DONE;
        end
        DONE: begin
          if (out_ready) begin
            if (accept) begin
              blk_d   = in_block ^ in_key;
              key_d   = in_key;
              round_d = 4'd1;
              fsm_d   = ROUND;
            end else begin
              round_d = '0;
              fsm_d   = IDLE;
            end
          end
        end
        default: begin
          fsm_d   = IDLE;
          round_d = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: FIPS-197 vectors, backpressure, back-to-back,
// flush, async reset and randomized blocks against a behavioural AES model.
`timescale 1ns/1ps
module tb_aes_round_sequencer;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_block;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;
  logic         busy;
  logic [3:0]   round_idx;

  aes_round_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .busy      (busy),
    .round_idx (round_idx)
  );

  // ---------------- clock / cycle count ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cyc=%0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h (cyc=%0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- behavioural AES-128 model ----------------
  logic [7:0] sbox_m [256];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse then the affine map.
  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox_m[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  // FIPS-197 style: 44-word key expansion, 4x4 state matrix s[row][col].
  function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   rc;
    logic [31:0]  tmp;
    logic [127:0] res;
    for (int i = 0; i < 4; i++)
      w[i] = {key[32*i +: 8], key[32*i+8 +: 8], key[32*i+16 +: 8], key[32*i+24 +: 8]};
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) s[r][c] = pt[8*(r+4*c) +: 8] ^ w[c][31-8*r -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r][c] = sbox_m[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          if (rnd < 10)
            s[r][c] = gmul(t[r][c], 8'h02) ^ gmul(t[(r+1)%4][c], 8'h03) ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
          else
            s[r][c] = t[r][c];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) s[r][c] = s[r][c] ^ w[4*rnd+c][31-8*r -: 8];
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) res[8*(r+4*c) +: 8] = s[r][c];
    return res;
  endfunction

  // FIPS hex strings list byte 0 first; the port puts byte 0 in bits [7:0].
  function automatic logic [127:0] fips(input logic [127:0] h);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = h[127-8*i -: 8];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [127:0] exp_q[$];
  int           acc_q[$];
  logic         prev_hold = 1'b0;
  logic         prev_ov = 1'b0;
  logic [127:0] prev_blk = '0;

  always @(negedge clk) begin
    if (rst || flush) begin
      exp_q.delete();
      acc_q.delete();
      prev_hold = 1'b0;
      prev_ov   = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_block", out_block, prev_blk);
      end
      if (out_valid) check("valid_not_busy", busy, 0);
      // accept seen here at cyc=k; ciphertext visible after the 10th later edge -> cyc=k+11
      if (out_valid && !prev_ov && acc_q.size() > 0) check("latency", cyc - acc_q[0], 11);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", exp_q.size(), 1);
        else begin
          check("ct_model", out_block, exp_q.pop_front());
          void'(acc_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model_encrypt(in_block, in_key));
        acc_q.push_back(cyc);
      end
      prev_hold = out_valid && !out_ready;
      prev_blk  = out_block;
      prev_ov   = out_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic accept(input logic [127:0] pt, input logic [127:0] key);
    int n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_block = pt; in_key = key;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    check("accept_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_block = rand128(); in_key = rand128();
  endtask

  task automatic wait_out(input string tag, input logic [127:0] exp);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    if (!out_valid) check({tag, "_timeout"}, out_valid, 1);
    else            check(tag, out_block, exp);
  endtask

  task automatic take();
    @(posedge clk); #1; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic wait_round(input logic [3:0] r);
    int n = 0;
    @(negedge clk);
    while (round_idx != r && n < 40) begin @(negedge clk); n++; end
    check("wait_round", round_idx, r);
  endtask

  // ---------------- main sequence ----------------
  logic [127:0] pt1, key1, ct1, pt2, key2, ct2, rk10;
  int c1, c2, n, seen_ov;
  logic got_it;

  initial begin
    in_valid = 0; in_block = '0; in_key = '0; out_ready = 0; flush = 0; rst = 1;
    pt1  = fips(128'h3243f6a8885a308d313198a2e0370734);
    key1 = fips(128'h2b7e151628aed2a6abf7158809cf4f3c);
    ct1  = fips(128'h3925841d02dc09fbdc118597196a0b32);
    pt2  = fips(128'h00112233445566778899aabbccddeeff);
    key2 = fips(128'h000102030405060708090a0b0c0d0e0f);
    ct2  = fips(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    rk10 = fips(128'h13111d7fe3944a17f307a78b4d2b30c5);
    build_sbox();

    // reset values
    #3;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_round_idx", round_idx, 0);
    check("rst_out_block", out_block, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);

    // FIPS-197 App.B
    accept(pt1, key1);
    wait_out("fips_b_ct", ct1);
    take();

    // FIPS-197 App.C.1 plus the final round key
    accept(pt2, key2);
    wait_out("fips_c1_ct", ct2);
    check("fips_c1_rk10", dut.key_q, rk10);
    take();

    // backpressure: 20 cycles of out_ready=0 with a competing in_valid
    accept(pt1, key1);
    wait_out("bp_ct", ct1);
    @(posedge clk); #1; in_valid = 1'b1; in_block = pt2; in_key = key2;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    take();
    @(negedge clk);
    check("bp_idle_busy", busy, 0);
    check("bp_idle_valid", out_valid, 0);

    // back-to-back with out_ready held high
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; in_block = pt1; in_key = key1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    c1 = cyc;
    @(posedge clk); #1; in_block = pt2; in_key = key2;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    c2 = cyc;
    check("b2b_spacing", c2 - c1, 11);
    check("b2b_ct1_valid", out_valid, 1);
    check("b2b_ct1", out_block, ct1);
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    check("b2b_no_idle", busy, 1);
    wait_out("b2b_ct2", ct2);
    @(posedge clk); #1; out_ready = 1'b0;

    // flush at round 5, then a clean block with the other key
    accept(pt2, key2);
    wait_round(4'd4);
    @(posedge clk); #1;
    check("flush_at_round", round_idx, 5);
    flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    check("flush_busy", busy, 0);
    check("flush_round_idx", round_idx, 0);
    check("flush_in_ready", in_ready, 1);
    seen_ov = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen_ov++;
    end
    check("flush_no_valid", seen_ov, 0);
    accept(pt1, key1);
    wait_out("flush_next_ct", ct1);
    take();

    // async reset mid-round, off the clock edge
    accept(pt1, key1);
    wait_round(4'd3);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_round_idx", round_idx, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_out_block", out_block, 0);
    @(posedge clk); @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    check("arst_release_ready", in_ready, 1);
    accept(pt2, key2);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1; in_block = rand128(); in_key = rand128();
    end
    wait_out("arst_ct2", ct2);
    take();

    // randomized blocks with random output backpressure
    for (int k = 0; k < 24; k++) begin
      accept(rand128(), rand128());
      got_it = 1'b0;
      for (int i = 0; i < 80 && !got_it; i++) begin
        @(posedge clk); #1; out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (out_valid && out_ready) got_it = 1'b1;
      end
      check("rand_drain", got_it, 1);
      @(posedge clk); #1; out_ready = 1'b0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
